pe_mm: RTL and testbench

- Next-generation weight-stationary systolic processing element for the tiny-tpu array.
- Generalises the multi-mode PE: parametrised operand/accumulator widths and an optional registered multiplier stage.
- Adds explicit weight-bank ownership, saturating accumulation and a sticky overflow flag.
- Tiles N×N inside the systolic array: activations flow east, weights and psums flow south.

---
 rtl/tpu_pkg.sv | 39 +++
 rtl/pe_mm_if.sv | 34 +++
 rtl/pe_mm_alu.sv | 38 +++
 rtl/pe_mm.sv | 154 +++++++++++++++
 tb/tb_pe_mm.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the tiny-tpu processing elements.
// Pulled in with import tpu_pkg::* by the PE and its ALU.
package tpu_pkg;

    typedef enum logic [1:0] {
        MODE_FULL  = 2'b00,
        MODE_PACK2 = 2'b01,
        MODE_PACK4 = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Working width of sat_add; callers sign-extend into it.
    localparam int SAT_W = 64;

    // Adds two values that each fit in 'width' signed bits and returns {ovf, result}.
    // With sat=0 the result is the plain sum, so its low 'width' bits are the wrapped value.
    function automatic logic [SAT_W:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             width,
        input logic                    sat = 1'b1
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] res;
        logic                    ovf;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        ovf   = (sum > max_v) || (sum < min_v);
        res   = sum;
        if (ovf && sat) begin
            res = (sum > max_v) ? max_v : min_v;
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/pe_mm_if.sv
// Port bundle of one pe_mm tile: north/west inputs, south/east outputs.
// The array (or bench) drives through master; the PE sits on slave.
interface pe_mm_if #(
    parameter int DATA_W = 16,
    parameter int PSUM_W = 32
);
    logic              en;
    logic [1:0]        mode;
    logic              sat_en;
    logic [PSUM_W-1:0] psum_in;
    logic [DATA_W-1:0] weight_in;
    logic              accept_w_in;
    logic [DATA_W-1:0] act_in;
    logic              valid_in;
    logic              switch_in;
    logic [PSUM_W-1:0] psum_out;
    logic [DATA_W-1:0] weight_out;
    logic              accept_w_out;
    logic [DATA_W-1:0] act_out;
    logic              valid_out;
    logic              switch_out;
    logic              psum_valid;
    logic              ovf;

    modport master (
        output en, mode, sat_en, psum_in, weight_in, accept_w_in, act_in, valid_in, switch_in,
        input  psum_out, weight_out, accept_w_out, act_out, valid_out, switch_out, psum_valid, ovf
    );

    modport slave (
        input  en, mode, sat_en, psum_in, weight_in, accept_w_in, act_in, valid_in, switch_in,
        output psum_out, weight_out, accept_w_out, act_out, valid_out, switch_out, psum_valid, ovf
    );
endinterface

// File: rtl/pe_mm_alu.sv
// Combinational lane-sliced signed multiply-sum for pe_mm.
// Every lane product is formed at ALU_W bits so the lane sum never overflows.
module pe_mm_alu
    import tpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ALU_W  = 2 * DATA_W + 2
) (
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] w,
    input  mode_e             mode,
    output logic [ALU_W-1:0]  prod
);
    localparam int H = DATA_W / 2;
    localparam int Q = DATA_W / 4;

    logic signed [ALU_W-1:0] p_full;
    logic signed [ALU_W-1:0] p_pack2;
    logic signed [ALU_W-1:0] p_pack4;

    always_comb begin
        p_full  = ALU_W'($signed(act)) * ALU_W'($signed(w));
        p_pack2 = '0;
        for (int i = 0; i < 2; i++) begin
            p_pack2 += ALU_W'($signed(act[i*H +: H])) * ALU_W'($signed(w[i*H +: H]));
        end
        p_pack4 = '0;
        for (int i = 0; i < 4; i++) begin
            p_pack4 += ALU_W'($signed(act[i*Q +: Q])) * ALU_W'($signed(w[i*Q +: Q]));
        end
        case (mode)
            MODE_FULL:  prod = p_full;
            MODE_PACK2: prod = p_pack2;
            MODE_PACK4: prod = p_pack4;
            default:    prod = '0;
        endcase
    end
endmodule

// File: rtl/pe_mm.sv
// Weight-stationary systolic PE: double-buffered weight, east/south forwarding,
// optional multiplier register, saturating/wrapping accumulate with sticky overflow.
module pe_mm
    import tpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PSUM_W     = 32,
    parameter int MUL_STAGES = 0
) (
    input logic   clk,
    input logic   rst,
    pe_mm_if.slave bus
);
    localparam int ALU_W = 2 * DATA_W + 2;

    logic [DATA_W-1:0] act_q, act_d;
    logic              valid_q, valid_d;
    logic              switch_q, switch_d;
    logic [DATA_W-1:0] weight_q, weight_d;
    logic              accept_q, accept_d;
    logic [DATA_W-1:0] fg_q, fg_d;
    logic [DATA_W-1:0] bg_q, bg_d;
    logic [PSUM_W-1:0] psum_q, psum_d;
    logic              psum_valid_q, psum_valid_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mul_w;
    logic [ALU_W-1:0]  prod;
    logic [ALU_W-1:0]  fin_prod;
    logic              fin_valid;
    logic              fin_sat;
    logic [SAT_W:0]    sum_ext;
    logic              unused_sum_hi;

    // A switch in the same cycle as a weight load multiplies with the incoming weight.
    always_comb begin
        if (bus.switch_in && bus.accept_w_in) begin
            mul_w = bus.weight_in;
        end else if (bus.switch_in) begin
            mul_w = bg_q;
        end else begin
            mul_w = fg_q;
        end
    end

    pe_mm_alu #(
        .DATA_W (DATA_W),
        .ALU_W  (ALU_W)
    ) u_alu (
        .act  (bus.act_in),
        .w    (mul_w),
        .mode (mode_e'(bus.mode)),
        .prod (prod)
    );

    // sat_en travels with its product so in-flight entries keep the setting they were issued with.
    if (MUL_STAGES == 1) begin : g_mul_stage
        logic [ALU_W-1:0] prod_q, prod_d;
        logic             pv_q, pv_d;
        logic             sat_q, sat_d;

        always_comb begin
            prod_d = bus.en ? prod : '0;
            pv_d   = bus.en & bus.valid_in;
            sat_d  = bus.en & bus.sat_en;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prod_q <= '0;
                pv_q   <= 1'b0;
                sat_q  <= 1'b0;
            end else begin
                prod_q <= prod_d;
                pv_q   <= pv_d;
                sat_q  <= sat_d;
            end
        end

        assign fin_prod  = prod_q;
        assign fin_valid = pv_q;
        assign fin_sat   = sat_q;
    end else begin : g_no_stage
        assign fin_prod  = prod;
        assign fin_valid = bus.valid_in;
        assign fin_sat   = bus.sat_en;
    end

    assign sum_ext       = sat_add(SAT_W'($signed(bus.psum_in)), SAT_W'($signed(fin_prod)), PSUM_W, fin_sat);
    assign unused_sum_hi = ^sum_ext[SAT_W-1:PSUM_W];

    always_comb begin
        act_d        = bus.valid_in ? bus.act_in : act_q;
        valid_d      = bus.valid_in;
        switch_d     = bus.switch_in;
        weight_d     = bus.accept_w_in ? bus.weight_in : '0;
        accept_d     = bus.accept_w_in;
        bg_d         = bus.accept_w_in ? bus.weight_in : bg_q;
        fg_d         = fg_q;
        if (bus.switch_in) begin
            fg_d = bus.accept_w_in ? bus.weight_in : bg_q;
        end
        psum_d       = fin_valid ? sum_ext[PSUM_W-1:0] : '0;
        psum_valid_d = fin_valid;
        ovf_d        = ovf_q | (fin_valid & sum_ext[SAT_W]);
        if (!bus.en) begin
            act_d        = '0;
            valid_d      = 1'b0;
            switch_d     = 1'b0;
            weight_d     = '0;
            accept_d     = 1'b0;
            bg_d         = '0;
            fg_d         = '0;
            psum_d       = '0;
            psum_valid_d = 1'b0;
            ovf_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q        <= '0;
            valid_q      <= 1'b0;
            switch_q     <= 1'b0;
            weight_q     <= '0;
            accept_q     <= 1'b0;
            fg_q         <= '0;
            bg_q         <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            act_q        <= act_d;
            valid_q      <= valid_d;
            switch_q     <= switch_d;
            weight_q     <= weight_d;
            accept_q     <= accept_d;
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.psum_out     = psum_q;
    assign bus.psum_valid   = psum_valid_q;
    assign bus.ovf          = ovf_q;
    assign bus.act_out      = act_q;
    assign bus.valid_out    = valid_q;
    assign bus.switch_out   = switch_q;
    assign bus.weight_out   = weight_q;
    assign bus.accept_w_out = accept_q;
endmodule

// File: tb/tb_pe_mm.sv
// Bench for pe_mm: one stimulus stream drives a MUL_STAGES=0 and a MUL_STAGES=1 tile,
// both checked every cycle against an arithmetic reference model.
module tb_pe_mm;
    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        sat_en;
    logic [31:0] psum_in;
    logic [15:0] weight_in;
    logic        accept_w_in;
    logic [15:0] act_in;
    logic        valid_in;
    logic        switch_in;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle_n = 0;

    pe_mm_if #(.DATA_W(16), .PSUM_W(32)) if0 ();
    pe_mm_if #(.DATA_W(16), .PSUM_W(32)) if1 ();

    assign if0.en = en;            assign if1.en = en;
    assign if0.mode = mode;        assign if1.mode = mode;
    assign if0.sat_en = sat_en;    assign if1.sat_en = sat_en;
    assign if0.psum_in = psum_in;  assign if1.psum_in = psum_in;
    assign if0.weight_in = weight_in;     assign if1.weight_in = weight_in;
    assign if0.accept_w_in = accept_w_in; assign if1.accept_w_in = accept_w_in;
    assign if0.act_in = act_in;    assign if1.act_in = act_in;
    assign if0.valid_in = valid_in;       assign if1.valid_in = valid_in;
    assign if0.switch_in = switch_in;     assign if1.switch_in = switch_in;

    pe_mm #(.DATA_W(16), .PSUM_W(32), .MUL_STAGES(0)) u_pe0 (.clk(clk), .rst(rst), .bus(if0));
    pe_mm #(.DATA_W(16), .PSUM_W(32), .MUL_STAGES(1)) u_pe1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit [15:0] m_fg, m_bg, m_act, m_wo;
    bit        m_vo, m_so, m_ao;
    bit [31:0] m_psum0, m_psum1;
    bit        m_pv0, m_pv1, m_ovf0, m_ovf1;
    bit        m_st_v, m_st_sat;
    longint    m_st_p;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cycle_n, obs, exp);
        end
    endtask

    function automatic longint lane_val(bit [15:0] v, int idx, int q);
        longint u;
        u = longint'(v >> (idx * q)) & ((longint'(1) << q) - 1);
        if (u >= (longint'(1) << (q - 1))) u -= (longint'(1) << q);
        return u;
    endfunction

    function automatic longint ref_prod(bit [15:0] a, bit [15:0] w, bit [1:0] m);
        int     n;
        longint s;
        n = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 0;
        s = 0;
        for (int i = 0; i < n; i++) s += lane_val(a, i, 16 / n) * lane_val(w, i, 16 / n);
        return s;
    endfunction

    function automatic void ref_acc(input bit [31:0] ps, input longint p, input bit sat,
                                    output bit [31:0] res, output bit ov);
        longint s;
        s  = longint'($signed(ps)) + p;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (ov && sat) res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else           res = 32'(s);
    endfunction

    task automatic model_clear();
        m_fg = 0; m_bg = 0; m_act = 0; m_wo = 0; m_vo = 0; m_so = 0; m_ao = 0;
        m_psum0 = 0; m_psum1 = 0; m_pv0 = 0; m_pv1 = 0; m_ovf0 = 0; m_ovf1 = 0;
        m_st_v = 0; m_st_sat = 0; m_st_p = 0;
    endtask

    task automatic model_edge();
        bit [15:0] mw;
        longint    p;
        bit [31:0] r;
        bit        o;
        if (!en) begin
            model_clear();
            return;
        end
        mw = (switch_in && accept_w_in) ? weight_in : (switch_in ? m_bg : m_fg);
        p  = ref_prod(act_in, mw, mode);
        if (valid_in) begin
            ref_acc(psum_in, p, sat_en, r, o);
            m_psum0 = r; m_pv0 = 1; m_ovf0 |= o;
        end else begin
            m_psum0 = 0; m_pv0 = 0;
        end
        if (m_st_v) begin
            ref_acc(psum_in, m_st_p, m_st_sat, r, o);
            m_psum1 = r; m_pv1 = 1; m_ovf1 |= o;
        end else begin
            m_psum1 = 0; m_pv1 = 0;
        end
        m_st_v = valid_in; m_st_p = p; m_st_sat = sat_en;
        if (switch_in) m_fg = accept_w_in ? weight_in : m_bg;
        if (accept_w_in) m_bg = weight_in;
        if (valid_in) m_act = act_in;
        m_vo = valid_in;
        m_so = switch_in;
        m_wo = accept_w_in ? weight_in : 16'h0;
        m_ao = accept_w_in;
    endtask

    task automatic compare_all();
        check("psum_s0", if0.psum_out, m_psum0);
        check("pvld_s0", if0.psum_valid, m_pv0);
        check("ovf_s0", if0.ovf, m_ovf0);
        check("psum_s1", if1.psum_out, m_psum1);
        check("pvld_s1", if1.psum_valid, m_pv1);
        check("ovf_s1", if1.ovf, m_ovf1);
        check("act_s0", if0.act_out, m_act);
        check("vout_s0", if0.valid_out, m_vo);
        check("swout_s0", if0.switch_out, m_so);
        check("wout_s0", if0.weight_out, m_wo);
        check("accw_s0", if0.accept_w_out, m_ao);
        check("act_s1", if1.act_out, m_act);
        check("vout_s1", if1.valid_out, m_vo);
        check("swout_s1", if1.switch_out, m_so);
        check("wout_s1", if1.weight_out, m_wo);
        check("accw_s1", if1.accept_w_out, m_ao);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        cycle_n++;
        compare_all();
    endtask

    task automatic do_async_rst();
        rst = 1'b1;
        #1;
        model_clear();
        compare_all();
        rst = 1'b0;
        #1;
    endtask

    task automatic idle();
        valid_in = 0; accept_w_in = 0; switch_in = 0; psum_in = 0; sat_en = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; sat_en = 0; psum_in = 0; weight_in = 0;
        accept_w_in = 0; act_in = 0; valid_in = 0; switch_in = 0;
        model_clear();
        #12;
        compare_all();
        check("rst_psum", if1.psum_out, 32'h0);
        rst = 1'b0; en = 1'b1;

        // full-width mode, w=3, act=-7, psum_in=100
        idle(); weight_in = 16'd3; accept_w_in = 1; cyc();
        accept_w_in = 0; switch_in = 1; cyc();
        switch_in = 0; mode = 2'd0; act_in = 16'hFFF9; valid_in = 1; psum_in = 32'd100; cyc();
        check("full_psum", if0.psum_out, 32'd79);
        check("full_pvld", if0.psum_valid, 1'b1);
        check("full_act", if0.act_out, 16'hFFF9);
        check("full_vout", if0.valid_out, 1'b1);
        valid_in = 0; cyc();
        check("full_psum_s1", if1.psum_out, 32'd79);
        check("act_hold", if0.act_out, 16'hFFF9);

        // packed modes, weight loaded by same-cycle switch+accept
        idle(); mode = 2'd1; weight_in = 16'h0304; accept_w_in = 1; switch_in = 1;
        act_in = 16'h02FD; valid_in = 1; cyc();
        check("pack2", if0.psum_out, 32'hFFFF_FFFA);
        idle(); cyc();
        check("pack2_s1", if1.psum_out, 32'hFFFF_FFFA);
        idle(); mode = 2'd2; weight_in = 16'h1111; accept_w_in = 1; switch_in = 1;
        act_in = 16'h7F81; valid_in = 1; cyc();
        check("pack4", if0.psum_out, 32'hFFFF_FFFF);
        idle(); cyc();
        check("pack4_s1", if1.psum_out, 32'hFFFF_FFFF);

        // reserved mode passes psum_in through
        idle(); mode = 2'd3; act_in = 16'h1234; valid_in = 1; psum_in = 32'd555; cyc();
        check("rsvd", if0.psum_out, 32'd555);

        // switch bypass
        idle(); mode = 2'd0; weight_in = 16'd2; accept_w_in = 1; switch_in = 1; cyc();
        idle(); weight_in = 16'd9; accept_w_in = 1; switch_in = 1; act_in = 16'd1; valid_in = 1; cyc();
        check("byp_same", if0.psum_out, 32'd9);
        accept_w_in = 0; switch_in = 0; cyc();
        check("byp_next", if0.psum_out, 32'd9);

        // saturation then wrap, ovf sticky
        idle(); weight_in = 16'd1; accept_w_in = 1; switch_in = 1; cyc();
        idle(); act_in = 16'd16; valid_in = 1; psum_in = 32'h7FFF_FFF0; sat_en = 1; cyc();
        check("sat_psum", if0.psum_out, 32'h7FFF_FFFF);
        check("sat_ovf", if0.ovf, 1'b1);
        sat_en = 0; cyc();
        check("wrap_psum", if0.psum_out, 32'h8000_0000);
        check("sat_psum_s1", if1.psum_out, 32'h7FFF_FFFF);
        valid_in = 0; cyc();
        check("wrap_psum_s1", if1.psum_out, 32'h8000_0000);
        idle(); cyc();
        check("ovf_sticky", if0.ovf, 1'b1);

        // en pulse clears banks and ovf
        en = 0; cyc();
        check("en_ovf", if0.ovf, 1'b0);
        en = 1; act_in = 16'd5; valid_in = 1; psum_in = 32'd1234; cyc();
        check("en_psum", if0.psum_out, 32'd1234);
        valid_in = 0; cyc();
        check("en_psum_s1", if1.psum_out, 32'd1234);

        // registered multiplier timing: acts 1,2,3 with w=2, then a gap
        idle(); weight_in = 16'd2; accept_w_in = 1; switch_in = 1; cyc();
        idle();
        act_in = 16'd1; valid_in = 1; cyc();
        check("pipe_lat", if1.psum_valid, 1'b0);
        act_in = 16'd2; cyc();
        check("pipe_a1", if1.psum_out, 32'd2);
        act_in = 16'd3; cyc();
        check("pipe_a2", if1.psum_out, 32'd4);
        valid_in = 0; cyc();
        check("pipe_a3", if1.psum_out, 32'd6);
        cyc();
        check("pipe_gap", if1.psum_out, 32'd0);
        check("pipe_gap_v", if1.psum_valid, 1'b0);

        // reset with an entry in flight
        act_in = 16'd3; valid_in = 1; cyc();
        do_async_rst();
        check("rst_mid_v", if1.psum_valid, 1'b0);
        valid_in = 0; cyc();
        check("rst_flush_v", if1.psum_valid, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            en     = ($urandom_range(0, 39) != 0);
            mode   = 2'($urandom_range(0, 3));
            sat_en = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       psum_in = 32'h7FFF_FF00 + $urandom_range(0, 255);
                1:       psum_in = 32'h8000_0000 + $urandom_range(0, 255);
                default: psum_in = $urandom;
            endcase
            weight_in   = 16'($urandom);
            act_in      = 16'($urandom);
            valid_in    = ($urandom_range(0, 3) != 0);
            accept_w_in = ($urandom_range(0, 2) == 0);
            switch_in   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) do_async_rst();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
